// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared types for the Wishbone command master.
// FSM state, buffered command and response bundles.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/wb_cmd_if.sv
// wb_cmd_if: command stream, response stream and WB master bus.
// master = initiator view (wb_cmd_master); slave = command source,
// response sink and WB target view.
interface wb_cmd_if;

    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_tmo_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_adr_o;
    logic        wbm_we_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o,
        output wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o,
        input  wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );

endinterface

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: synchronous FIFO, async active-high reset.
// Ports: clk, rst, push/din, pop/dout (head), full, empty.
module wb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a full FIFO never takes a write, even alongside a pop
    assign do_push = push && !full;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: classic Wishbone initiator fed by a command FIFO.
// Ports: wbm_clk_i, wbm_rst_i, bus (wb_cmd_if.master: cmd/rsp streams + WB).
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic     wbm_clk_i,
    input  logic     wbm_rst_i,
    wb_cmd_if.master bus
);

    localparam int CW = $clog2(TIMEOUT);

    state_e        state;
    state_e        state_nx;
    cmd_t          fifo_din;
    cmd_t          head;
    cmd_t          wb_q;
    rsp_t          rsp_q;
    logic [CW-1:0] tmo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          hit_ack;
    logic          hit_err;
    logic          hit_tmo;
    logic          req_done;
    logic          rsp_fire;

    assign fifo_din = '{
        we:  bus.cmd_we_i,
        adr: bus.cmd_adr_i,
        dat: bus.cmd_dat_i,
        sel: bus.cmd_sel_i
    };

    assign fifo_push = bus.cmd_valid_i && bus.cmd_ready_o;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    // err beats ack; either beats a timeout landing on the same edge
    assign hit_err  = (state == REQ) && bus.wbm_err_i;
    assign hit_ack  = (state == REQ) && bus.wbm_ack_i && !bus.wbm_err_i;
    assign hit_tmo  = (state == REQ) && !bus.wbm_ack_i && !bus.wbm_err_i
                   && (tmo_cnt == CW'(TIMEOUT - 1));
    assign req_done = hit_ack || hit_err || hit_tmo;
    assign rsp_fire = (state == RESP) && bus.rsp_ready_i;

    wb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (wbm_clk_i),
        .rst   (wbm_rst_i),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
        if (wbm_rst_i) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (fifo_pop) state_nx = REQ;
            REQ:     if (req_done) state_nx = RESP;
            RESP:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cyc/stb decode straight from the state flop, so reset drops them at once
    always_comb begin
        bus.wbm_cyc_o   = (state == REQ);
        bus.wbm_stb_o   = (state == REQ);
        bus.wbm_we_o    = wb_q.we;
        bus.wbm_adr_o   = wb_q.adr;
        bus.wbm_dat_o   = wb_q.dat;
        bus.wbm_sel_o   = wb_q.sel;
        bus.rsp_valid_o = (state == RESP);
        bus.rsp_dat_o   = rsp_q.dat;
        bus.rsp_err_o   = rsp_q.err;
        bus.rsp_tmo_o   = rsp_q.tmo;
        bus.cmd_ready_o = !fifo_full && !wbm_rst_i;
    end

    always_ff @(posedge wbm_clk_i or posedge wbm_rst_i) begin
        if (wbm_rst_i) begin
            wb_q    <= '0;
            rsp_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            if (fifo_pop)      wb_q <= head;
            else if (req_done) wb_q <= '0;

            if ((state == REQ) && !req_done) tmo_cnt <= tmo_cnt + 1'b1;
            else if (rsp_fire)               tmo_cnt <= '0;

            unique case (1'b1)
                hit_ack: rsp_q <= '{
                    dat: wb_q.we ? 32'h0 : bus.wbm_dat_i,
                    err: 1'b0,
                    tmo: 1'b0
                };
                hit_err:  rsp_q <= '{dat: 32'h0, err: 1'b1, tmo: 1'b0};
                hit_tmo:  rsp_q <= '{dat: 32'h0, err: 1'b1, tmo: 1'b1};
                rsp_fire: rsp_q <= '0;
                default:  rsp_q <= rsp_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench for wb_cmd_master.
// Reference memory + per-command slave plan predict each response.
module tb_wb_cmd_master;
    import wb_cmd_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;
    typedef struct {
        kind_e kind;
        int    delay;
    } plan_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_cmd_if bus();

    wb_cmd_master #(
        .CMD_DEPTH (DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .wbm_clk_i (clk),
        .wbm_rst_i (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    rsp_t        exp_q[$];
    plan_t       plan_q[$];
    int          runs_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] smem    [logic [31:0]];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          rdy_pct  = 100;
    int          accepted = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // WB target: follows the plan queued with each command
    initial begin : slave
        plan_t       cur;
        int          wait_n;
        bit          active;
        logic [31:0] a;
        active = 0;
        wait_n = 0;
        cur.kind = K_NONE;
        cur.delay = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = 32'h0;
            if (!bus.wbm_cyc_o) begin
                active = 0;
            end else begin
                if (!active) begin
                    active = 1;
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else begin cur.kind = K_NONE; cur.delay = 0; end
                    wait_n = cur.delay;
                end
                a = bus.wbm_adr_o >> 2;
                if (wait_n > 0) begin
                    wait_n--;
                end else begin
                    case (cur.kind)
                        K_ACK: begin
                            bus.wbm_ack_i = 1'b1;
                            if (bus.wbm_we_o)
                                smem[a] = merge(smem.exists(a) ? smem[a] : 32'h0,
                                                bus.wbm_dat_o, bus.wbm_sel_o);
                            else
                                bus.wbm_dat_i = smem.exists(a) ? smem[a] : 32'h0;
                        end
                        K_ERR: bus.wbm_err_i = 1'b1;
                        K_BOTH: begin
                            bus.wbm_ack_i = 1'b1;
                            bus.wbm_err_i = 1'b1;
                            bus.wbm_dat_i = smem.exists(a) ? smem[a] : 32'hDEAD_BEEF;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // response monitor: drives rsp_ready, pops and compares on handshake
    initial begin : monitor
        rsp_t e;
        int   run;
        run = 0;
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready_i = ($urandom_range(0, 99) < rdy_pct);
            if (bus.wbm_cyc_o) run++;
            else if (run > 0) begin runs_q.push_back(run); run = 0; end
            if (bus.wbm_cyc_o)
                check("stb_eq_cyc", 64'(bus.wbm_stb_o), 64'(1));
            if (bus.rsp_valid_o) begin
                check("cyc_during_rsp", 64'(bus.wbm_cyc_o), 64'(0));
                if (bus.rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", 64'({bus.rsp_dat_o, bus.rsp_err_o,
                                          bus.rsp_tmo_o}), 64'(e));
                    end
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input kind_e k, input int dly);
        int          g;
        rsp_t        e;
        plan_t       p;
        logic [31:0] a;
        g = 0;
        a = adr >> 2;
        @(negedge clk);
        while (!bus.cmd_ready_o) begin
            g++;
            if (g > 3000) begin
                check("cmd_ready_wait", 64'(0), 64'(1));
                return;
            end
            @(negedge clk);
        end
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        bus.cmd_valid_i = 1'b1;
        p.kind  = k;
        p.delay = dly;
        plan_q.push_back(p);
        e = '0;
        case (k)
            K_ACK:
                if (we) ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0,
                                           dat, sel);
                else    e.dat = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            K_ERR, K_BOTH: e.err = 1'b1;
            default: begin e.err = 1'b1; e.tmo = 1'b1; end
        endcase
        exp_q.push_back(e);
        accepted++;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_drain"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          g;
        logic        we;
        logic [31:0] adr;
        int          r;
        kind_e       k;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.cmd_sel_i   = 4'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc",     64'(bus.wbm_cyc_o),   64'(0));
        check("rst_rsp_vld", 64'(bus.rsp_valid_o), 64'(0));
        check("rst_ready",   64'(bus.cmd_ready_o), 64'(0));
        check("rst_adr",     64'(bus.wbm_adr_o),   64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.cmd_ready_o), 64'(1));

        send(1'b1, 32'h3000_0000, 32'h1122_3344, 4'hF, K_ACK, 0);
        send(1'b1, 32'h3000_0004, 32'h5566_7788, 4'hF, K_ACK, 1);
        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, K_ACK, 0);
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, K_ACK, 2);
        drain("basic");

        runs_q.delete();
        send(1'b0, 32'h3000_0008, 32'h0, 4'hF, K_NONE, 0);
        send(1'b1, 32'h3000_000C, 32'hCAFE_F00D, 4'hF, K_ACK, 0);
        send(1'b0, 32'h3000_000C, 32'h0, 4'hF, K_ACK, 3);
        drain("tmo");
        @(negedge clk);
        check("tmo_cyc_len", 64'(runs_q.size() > 0 ? runs_q[0] : -1), 64'(TMO));

        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, K_BOTH, 1);
        send(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, K_ERR, 2);
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, K_ACK, 0);
        drain("err");

        rdy_pct  = 0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1'b1, 32'h3000_0010 + 32'(i * 4), $urandom, 4'hF, K_ACK, 0);
            end
        join_none
        repeat (30) @(negedge clk);
        check("bp_ready_low", 64'(bus.cmd_ready_o), 64'(0));
        check("bp_accepted",  64'(accepted),        64'(DEPTH + 1));
        rdy_pct = 100;
        g = 0;
        while (accepted < 6 && g < 500) begin @(negedge clk); g++; end
        check("bp_all_accepted", 64'(accepted), 64'(6));
        drain("bp");
        for (int i = 0; i < 6; i++)
            send(1'b0, 32'h3000_0010 + 32'(i * 4), 32'h0, 4'hF, K_ACK, 0);
        drain("bp_read");

        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, K_NONE, 0);
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, K_NONE, 0);
        g = 0;
        while (!bus.wbm_cyc_o && g < 100) begin @(negedge clk); g++; end
        check("pre_rst_cyc", 64'(bus.wbm_cyc_o), 64'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cyc",     64'(bus.wbm_cyc_o),   64'(0));
        check("arst_stb",     64'(bus.wbm_stb_o),   64'(0));
        check("arst_ready",   64'(bus.cmd_ready_o), 64'(0));
        check("arst_rsp_vld", 64'(bus.rsp_valid_o), 64'(0));
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        check("arst_hold_rsp", 64'(bus.rsp_valid_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("arst_rel_ready", 64'(bus.cmd_ready_o), 64'(1));
        send(1'b1, 32'h3000_0020, 32'hA5A5_5A5A, 4'hF, K_ACK, 0);
        send(1'b0, 32'h3000_0020, 32'h0, 4'hF, K_ACK, 1);
        drain("post_arst");

        rdy_pct = 70;
        for (int i = 0; i < 200; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = 32'h3000_0000 + 32'($urandom_range(0, 7) << 2);
            r   = $urandom_range(0, 19);
            k   = (r == 0) ? K_ERR : (r == 1) ? K_BOTH : K_ACK;
            send(we, adr, $urandom, 4'($urandom_range(0, 15)), k,
                 $urandom_range(0, 10));
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
